window_accumulator: RTL and testbench

WINDOW_ACCUMULATOR -- requirements
Module: window_accumulator

---
 rtl/acc_pkg.sv | 17 +
 rtl/window_accumulator_if.sv | 38 +++
 rtl/param_adder.sv | 20 ++
 rtl/window_accumulator.sv | 122 ++++++++++++
 tb/tb_window_accumulator.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared defaults and FSM encoding for window_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_WIN   = 9;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/window_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : window_accumulator_if
// Description : Sample-in / result-out handshake bundle for window_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface window_accumulator_if
    import acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int WIN   = DEF_WIN
) ();

    localparam int CNT_W = $clog2(WIN + 1);

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic [CNT_W-1:0]  win_cnt;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, win_cnt
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, win_cnt
    );

endinterface
`default_nettype wire

// File: rtl/param_adder.sv
`default_nettype none
// ============================================================================
// Module      : param_adder
// Description : W-bit unsigned adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module param_adder #(
    parameter int W = 16
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire logic         cin,
    output logic      [W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : window_accumulator
// Description : Sums WIN unsigned samples per window, saturating or wrapping,
//               and hands each window result out through a valid/ready stage.
// Revision    : 1.0 - initial release
// ============================================================================
module window_accumulator
    import acc_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int WIN    = DEF_WIN,
    parameter int SAT_EN = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    window_accumulator_if.slave bus
);

    localparam int               CNT_W  = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIN - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_ovf;

    logic [IN_W-1:0]  w_in_data;
    logic             w_hold;
    logic             w_last;
    logic             w_first;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_done;
    logic [ACC_W-1:0] w_addend_a;
    logic [ACC_W-1:0] w_addend_b;
    logic [ACC_W-1:0] w_sum;
    logic             w_cout;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;

    assign w_in_data  = bus.in_data;
    assign w_hold     = (r_state == S_HOLD);
    assign w_last     = (r_cnt == C_LAST);
    assign w_first    = (r_cnt == '0);
    // Stall only the closing sample: it would overwrite a result not yet taken.
    assign w_in_ready = !bus.clear && !(w_last && w_hold && !bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = w_hold && bus.out_ready;
    assign w_done     = w_accept && w_last;

    // First sample of a window loads rather than adds, so no stale sum leaks in.
    assign w_addend_a = w_first ? '0 : r_acc;
    assign w_addend_b = ACC_W'(w_in_data);

    param_adder #(
        .W (ACC_W)
    ) u_adder (
        .a    (w_addend_a),
        .b    (w_addend_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    generate
        if (SAT_EN != 0) begin : g_sat
            assign w_acc_next = w_cout ? '1 : w_sum;
        end else begin : g_wrap
            assign w_acc_next = w_sum;
        end
    endgenerate

    assign w_ovf_next = w_cout | (r_ovf & !w_first);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_ACC;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (bus.clear) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_cnt      <= '0;
                    r_acc      <= '0;
                    r_ovf      <= 1'b0;
                    r_out_data <= w_acc_next;
                    r_out_ovf  <= w_ovf_next;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                end
            end

            case (r_state)
                S_ACC:   if (w_done) r_state <= S_HOLD;
                S_HOLD:  if (w_pop && !w_done) r_state <= S_ACC;
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_hold;
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.win_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_accumulator
// Description : Randomised and directed self-checking bench for three
//               window_accumulator configurations driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_accumulator;

    localparam int WIN = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: window sample count, running true sum, held true sum.
    int       m_cnt  = 0;
    int       m_sum  = 0;
    int       m_true = 0;
    bit       m_vld  = 1'b0;
    bit       exp_rdy;
    logic [2:0] obs_rdy;

    always #5 clk = ~clk;

    window_accumulator_if #(.IN_W(8), .ACC_W(16), .WIN(WIN)) if_a ();
    window_accumulator_if #(.IN_W(8), .ACC_W(8),  .WIN(WIN)) if_s ();
    window_accumulator_if #(.IN_W(8), .ACC_W(8),  .WIN(WIN)) if_w ();

    assign if_a.clear = clear;  assign if_a.in_valid = in_valid;
    assign if_a.in_data = in_data;  assign if_a.out_ready = out_ready;
    assign if_s.clear = clear;  assign if_s.in_valid = in_valid;
    assign if_s.in_data = in_data;  assign if_s.out_ready = out_ready;
    assign if_w.clear = clear;  assign if_w.in_valid = in_valid;
    assign if_w.in_data = in_data;  assign if_w.out_ready = out_ready;

    window_accumulator #(.IN_W(8), .ACC_W(16), .WIN(WIN), .SAT_EN(1)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave));
    window_accumulator #(.IN_W(8), .ACC_W(8), .WIN(WIN), .SAT_EN(1)) u_dut_s (
        .clk (clk), .rst (rst), .bus (if_s.slave));
    window_accumulator #(.IN_W(8), .ACC_W(8), .WIN(WIN), .SAT_EN(0)) u_dut_w (
        .clk (clk), .rst (rst), .bus (if_w.slave));

    // Expected {valid, win_cnt, data16, ovf16, data8sat, ovf8sat, data8wrap, ovf8wrap}.
    function automatic logic [39:0] exp_out();
        int t;
        t = m_true;
        return {m_vld, 4'(m_cnt),
                16'((t > 65535) ? 65535 : t), 1'(t > 65535),
                8'((t > 255) ? 255 : t),      1'(t > 255),
                8'(t % 256),                  1'(t > 255)};
    endfunction

    function automatic logic [39:0] obs_out();
        return {if_a.out_valid, if_a.win_cnt, if_a.out_data, if_a.out_ovf,
                if_s.out_data, if_s.out_ovf, if_w.out_data, if_w.out_ovf};
    endfunction

    task automatic drive(input bit r, input bit clr, input bit v,
                         input logic [7:0] d, input bit rdy);
        bit done;
        rst = r; clear = clr; in_valid = v; in_data = d; out_ready = rdy;
        #1;
        exp_rdy = !clr && !(m_cnt == WIN - 1 && m_vld && !rdy);
        obs_rdy = {if_a.in_ready, if_s.in_ready, if_w.in_ready};
        done = 1'b0;
        if (r) begin
            m_cnt = 0; m_sum = 0; m_true = 0; m_vld = 1'b0;
        end else begin
            if (clr) begin
                m_cnt = 0; m_sum = 0;
            end else if (v && exp_rdy) begin
                m_sum += int'(d);
                if (m_cnt == WIN - 1) begin
                    m_true = m_sum; m_sum = 0; m_cnt = 0; done = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (done) m_vld = 1'b1;
            else if (m_vld && rdy) m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 1, 1, 8'h55, 1);
        checks++;
        if (obs_out() !== 40'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs_out(), 40'h0);
        end
        drive(0, 0, 0, 8'h00, 0);
        checks++;
        if (obs_rdy !== 3'b111) begin
            errors++; $display("FAIL reset_in_ready got %b exp 111", obs_rdy);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= WIN; i++) begin
            drive(0, 0, 1, 8'(i), 1);
            checks++;
            if (obs_out() !== exp_out()) begin
                errors++; $display("FAIL basic_step%0d got %h exp %h", i, obs_out(), exp_out());
            end
        end
        checks++;
        if (if_a.out_valid !== 1'b1 || if_a.out_data !== 16'd45 || if_a.out_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_sum45 got v=%b d=%0d o=%b exp v=1 d=45 o=0",
                               if_a.out_valid, if_a.out_data, if_a.out_ovf);
        end
        drive(0, 0, 0, 8'h00, 1);
        checks++;
        if (if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle got out_valid=%b exp 0", if_a.out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < WIN; i++) drive(0, 0, 1, 8'hFF, 1);
        checks++;
        if ({if_s.out_data, if_s.out_ovf, if_w.out_data, if_w.out_ovf} !== {8'd255, 1'b1, 8'd247, 1'b1}) begin
            errors++; $display("FAIL overflow_sat_wrap got s=%0d/%b w=%0d/%b exp s=255/1 w=247/1",
                               if_s.out_data, if_s.out_ovf, if_w.out_data, if_w.out_ovf);
        end
        checks++;
        if (obs_out() !== exp_out()) begin
            errors++; $display("FAIL overflow_model got %h exp %h", obs_out(), exp_out());
        end
        drive(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < WIN; i++) drive(0, 0, 1, 8'd1, 0);
        for (int i = 0; i < WIN - 1; i++) drive(0, 0, 1, 8'd2, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8'd2, 0);
            checks++;
            if (obs_rdy !== 3'b000 || obs_out() !== exp_out()) begin
                errors++; $display("FAIL stall_hold got rdy=%b out=%h exp rdy=000 out=%h",
                                   obs_rdy, obs_out(), exp_out());
            end
        end
        checks++;
        if (if_a.out_data !== 16'd9 || if_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_first got d=%0d v=%b exp d=9 v=1", if_a.out_data, if_a.out_valid);
        end
        drive(0, 0, 1, 8'd2, 1);
        checks++;
        if (obs_rdy !== 3'b111 || if_a.out_data !== 16'd18 || if_a.out_valid !== 1'b1
            || obs_out() !== exp_out()) begin
            errors++; $display("FAIL stall_replace got rdy=%b d=%0d v=%b exp rdy=111 d=18 v=1",
                               obs_rdy, if_a.out_data, if_a.out_valid);
        end
        drive(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'd10, 1);
        drive(0, 1, 1, 8'd99, 1);
        checks++;
        if (obs_rdy !== 3'b000 || if_a.win_cnt !== 4'd0) begin
            errors++; $display("FAIL clear_abort got rdy=%b cnt=%0d exp rdy=000 cnt=0", obs_rdy, if_a.win_cnt);
        end
        for (int i = 0; i < WIN; i++) drive(0, 0, 1, 8'd1, 1);
        checks++;
        if (if_a.out_data !== 16'd9 || if_a.out_valid !== 1'b1 || obs_out() !== exp_out()) begin
            errors++; $display("FAIL clear_sum9 got d=%0d v=%b exp d=9 v=1", if_a.out_data, if_a.out_valid);
        end
        drive(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < WIN; i++) drive(0, 0, 1, 8'd4, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'd4, 0);
        checks++;
        if (if_a.win_cnt !== 4'd5 || if_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup got cnt=%0d v=%b exp cnt=5 v=1", if_a.win_cnt, if_a.out_valid);
        end
        drive(1, 0, 1, 8'd4, 0);
        checks++;
        if (if_a.out_valid !== 1'b0 || if_a.win_cnt !== 4'd0 || obs_out() !== exp_out()) begin
            errors++; $display("FAIL rstmid_discard got v=%b cnt=%0d exp v=0 cnt=0", if_a.out_valid, if_a.win_cnt);
        end
        drive(0, 0, 1, 8'd3, 1);
        checks++;
        if (obs_rdy !== 3'b111) begin
            errors++; $display("FAIL rstmid_ready got %b exp 111", obs_rdy);
        end
        for (int i = 1; i < WIN; i++) drive(0, 0, 1, 8'd3, 1);
        checks++;
        if (if_a.out_data !== 16'd27 || if_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_sum27 got d=%0d v=%b exp d=27 v=1", if_a.out_data, if_a.out_valid);
        end
        drive(0, 0, 0, 8'h00, 1);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 800; i++) begin
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 30));
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 75, d, $urandom_range(0, 99) < 50);
            checks++;
            if (obs_rdy !== {3{exp_rdy}}) begin
                errors++; $display("FAIL random_in_ready cyc%0d got %b exp %b", i, obs_rdy, {3{exp_rdy}});
            end
            checks++;
            if (obs_out() !== exp_out()) begin
                errors++; $display("FAIL random_outputs cyc%0d got %h exp %h", i, obs_out(), exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_clear();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
